encap_result_reader: RTL and testbench
======================================

// Module: encap_result_reader
// PURPOSE
//  Read-out side of encap_seq_gen. After encapsulation completes, reads ciphertext C0, then C1, then
//  session key K out of the DUT result memories through the rd_*/*_addr/*_out ports. Serialises every
//  32-bit word into a byte stream with a valid/ready handshake, which feeds the board UART transmitter.
//  Sits beside encap_seq_gen in the FPGA top and replaces bench-side $writememb dumps on hardware.
// PARAMETERS
//  parameter_set  1    McEliece set 1..5. Derives m (12 for set 1, else 13) and t (64/96/128/119/128).
//  l              m*t  Syndrome length in bits.
//  C0_WORDS       (l+(32-l%32)%32)/32  Number of 32-bit C0 words (24 for set 1).
//  C1_WORDS       8    Number of 32-bit C1 words.
//  K_WORDS        8    Number of 32-bit K words.
//  READ_LATENCY   1    Cycles from the rd/addr cycle until *_out is valid. Range 1..3.
// PORTS
//  clk       in   1                  Clock.
//  rst       in   1                  Synchronous, active-high reset.
//  start     in   1                  Begin read-out; typically driven by encap_seq_gen done.
//  busy      out  1                  High from the cycle after start is accepted until done.
//  done      out  1                  One-cycle pulse after the last byte has been accepted.
//  rd_C0     out  1                  C0 memory read strobe.
//  C0_addr   out  CLOG2(C0_WORDS)    C0 word address.
//  C0_out    in   32                 C0 read data.
//  rd_C1     out  1                  C1 memory read strobe.
//  C1_addr   out  3                  C1 word address.
//  C1_out    in   32                 C1 read data.
//  rd_K      out  1                  K memory read strobe.
//  K_addr    out  3                  K word address.
//  K_out     in   32                 K read data.
//  tx_data   out  8                  Output byte.
//  tx_valid  out  1                  tx_data is valid.
//  tx_ready  in   1                  Sink accepts the byte; a transfer occurs when tx_valid && tx_ready.
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, region C0, word and byte counters 0. Reset mid-stream aborts
//   immediately with no done pulse.
//  FSM states:
//   IDLE: on start=1, go to REQ (region C0, addr 0). start is ignored in every other state.
//   REQ: one cycle. Drives rd_<region>=1 with <region>_addr = word index. All other rd_* are 0.
//   LOAD: READ_LATENCY cycles. In the last one, capture <region>_out into a 32-bit shift register.
//   SEND: tx_valid=1 with tx_data = shreg[7:0] (little-endian: byte0 = bits[7:0] first).
//    On each handshake, shift right by 8.
//    After the 4th handshake: if the word is not the last in its region, go to REQ with word+1.
//    Otherwise move to the next region (C0 -> C1 -> K) at word 0. After K word K_WORDS-1, go to DONE.
//   DONE: one cycle with done=1 and busy=0, then IDLE.
//  Handshake rules:
//   tx_data is stable and tx_valid is held while tx_ready=0.
//   tx_valid is registered and has no combinational path from tx_ready.
//   tx_ready high outside SEND has no effect.
//  Address outputs hold their last value outside REQ. They are only meaningful when rd_* is high.
//  C0 padding: when l%32 != 0, all 4 bytes of the last word are still sent, padding bits as stored.
//  Total bytes = 4*(C0_WORDS+C1_WORDS+K_WORDS); 160 for set 1.
//  Timing, with tx_ready held high:
//   each word takes 5+READ_LATENCY cycles;
//   start accepted at cycle 0, first REQ at cycle 1;
//   last handshake at cycle (C0_WORDS+16)*(5+READ_LATENCY);
//   done at the following cycle.
//  Back-to-back runs: start in the cycle after done begins a fresh run from C0 word 0.
// TESTING
//  1) Set 1, READ_LATENCY=1, memories C0[i]=32'hC000_0000+i, C1[i]=32'hC100_0000+i, K[i]=32'h4B00_0000+i,
//     tx_ready=1, start pulse -> 160 bytes. First bytes: 00 00 00 C0 01 00 00 C0.
//     Byte 96 = 00 (C1 word 0). Last 4 bytes: 07 00 00 4B. Last handshake at cycle 240, done at 241.
//  2) Random tx_ready, 30% duty -> same 160-byte sequence. tx_data is stable while tx_valid && !tx_ready.
//     Exactly one done pulse.
//  3) Check rd_* strobes -> exactly 24 rd_C0, 8 rd_C1 and 8 rd_K pulses, each one cycle long.
//     Addresses are sequential 0..N-1 and no two strobes are high together.
//  4) start re-asserted at cycles 50 and 100 of a run -> ignored. Byte count stays 160, one done.
//  5) rst asserted for 1 cycle after byte 70 -> all outputs 0 next cycle, no done.
//     A later start -> full 160 bytes from C0 word 0.
//  6) parameter_set=4 (C0_WORDS=49), READ_LATENCY=2 -> 260 bytes.
//     Last handshake at cycle 65*7=455, done at 456.

Source files
------------

// File: rtl/encap_result_reader.sv
// Streams encap_seq_gen results (C0, then C1, then K) out of the result memories
// as little-endian bytes over a valid/ready handshake toward the board UART.
module encap_result_reader #(
    parameter int parameter_set = 1,
    parameter int C1_WORDS      = 8,
    parameter int K_WORDS       = 8,
    parameter int READ_LATENCY  = 1,
    localparam int M        = (parameter_set == 1) ? 12 : 13,
    localparam int T        = (parameter_set == 1) ? 64 :
                              (parameter_set == 2) ? 96 :
                              (parameter_set == 4) ? 119 : 128,
    localparam int L        = M * T,
    localparam int C0_WORDS = (L + (32 - L % 32) % 32) / 32,
    localparam int C0_AW    = $clog2(C0_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_C0,
    output logic [C0_AW-1:0] C0_addr,
    input  logic [31:0]      C0_out,
    output logic             rd_C1,
    output logic [2:0]       C1_addr,
    input  logic [31:0]      C1_out,
    output logic             rd_K,
    output logic [2:0]       K_addr,
    input  logic [31:0]      K_out,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int CW = (C0_AW > 3) ? C0_AW : 3;

    typedef enum logic [2:0] {IDLE, REQ, LOAD, SEND, DONE} state_t;
    typedef enum logic [1:0] {R_C0, R_C1, R_K} region_t;

    state_t           state, state_nxt;
    region_t          region, region_nxt;
    logic [CW-1:0]    word_cnt, region_max;
    logic [1:0]       lat_cnt;
    logic [1:0]       byte_cnt;
    logic [31:0]      shreg, rd_data;
    logic [C0_AW-1:0] c0_addr_q;
    logic [2:0]       c1_addr_q, k_addr_q;
    logic             lat_last, word_last, hs_last;

    assign lat_last  = (lat_cnt == 2'(READ_LATENCY - 1));
    assign word_last = (word_cnt == region_max);
    assign hs_last   = (state == SEND) && tx_ready && (byte_cnt == 2'd3);

    always_comb begin
        region_max = CW'(K_WORDS - 1);
        region_nxt = R_K;
        rd_data    = K_out;
        case (region)
            R_C0: begin region_max = CW'(C0_WORDS - 1); region_nxt = R_C1; rd_data = C0_out; end
            R_C1: begin region_max = CW'(C1_WORDS - 1); region_nxt = R_K;  rd_data = C1_out; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ:  state_nxt = LOAD;
            LOAD: if (lat_last) state_nxt = SEND;
            SEND: if (hs_last) state_nxt = (word_last && region == R_K) ? DONE : REQ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == REQ) || (state == LOAD) || (state == SEND);
        done     = (state == DONE);
        tx_valid = (state == SEND);
        tx_data  = shreg[7:0];
        rd_C0    = (state == REQ) && (region == R_C0);
        rd_C1    = (state == REQ) && (region == R_C1);
        rd_K     = (state == REQ) && (region == R_K);
        // Address follows the word counter during REQ, then holds the issued value.
        C0_addr  = rd_C0 ? word_cnt[C0_AW-1:0] : c0_addr_q;
        C1_addr  = rd_C1 ? word_cnt[2:0]       : c1_addr_q;
        K_addr   = rd_K  ? word_cnt[2:0]       : k_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            region    <= R_C0;
            word_cnt  <= '0;
            lat_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            c0_addr_q <= '0;
            c1_addr_q <= '0;
            k_addr_q  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    region   <= R_C0;
                    word_cnt <= '0;
                end
                REQ: begin
                    lat_cnt <= '0;
                    case (region)
                        R_C0:    c0_addr_q <= word_cnt[C0_AW-1:0];
                        R_C1:    c1_addr_q <= word_cnt[2:0];
                        default: k_addr_q  <= word_cnt[2:0];
                    endcase
                end
                LOAD: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_last) begin
                        shreg    <= rd_data;
                        byte_cnt <= '0;
                    end
                end
                SEND: if (tx_ready) begin
                    shreg    <= {8'h00, shreg[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (word_last) begin
                            word_cnt <= '0;
                            region   <= region_nxt;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encap_result_reader.sv
// Drives two read-out configurations (set 1 / latency 1, set 4 / latency 2) against
// memory models and compares the byte stream with a queue built from memory contents.
module tb_encap_result_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: set 1, latency 1 ----------------
    logic        a_start, a_ready, a_busy, a_done, a_rd_C0, a_rd_C1, a_rd_K, a_tx_valid;
    logic [4:0]  a_C0_addr;
    logic [2:0]  a_C1_addr, a_K_addr;
    logic [31:0] a_C0_out, a_C1_out, a_K_out;
    logic [7:0]  a_tx_data;
    logic [31:0] a_c0 [0:23];
    logic [31:0] a_c1 [0:7];
    logic [31:0] a_k  [0:7];

    encap_result_reader #(.parameter_set(1), .READ_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .rd_C0(a_rd_C0), .C0_addr(a_C0_addr), .C0_out(a_C0_out),
        .rd_C1(a_rd_C1), .C1_addr(a_C1_addr), .C1_out(a_C1_out),
        .rd_K(a_rd_K), .K_addr(a_K_addr), .K_out(a_K_out),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_ready));

    always @(posedge clk) begin
        a_C0_out <= a_rd_C0 ? a_c0[a_C0_addr] : 32'hDEADBEEF;
        a_C1_out <= a_rd_C1 ? a_c1[a_C1_addr] : 32'hDEADBEEF;
        a_K_out  <= a_rd_K  ? a_k[a_K_addr]   : 32'hDEADBEEF;
    end

    // ---------------- DUT B: set 4, latency 2 ----------------
    logic        b_start, b_ready, b_busy, b_done, b_rd_C0, b_rd_C1, b_rd_K, b_tx_valid;
    logic [5:0]  b_C0_addr;
    logic [2:0]  b_C1_addr, b_K_addr;
    logic [31:0] b_C0_out, b_C1_out, b_K_out, b_s0, b_s1, b_s2;
    logic [7:0]  b_tx_data;
    logic [31:0] b_c0 [0:48];
    logic [31:0] b_c1 [0:7];
    logic [31:0] b_k  [0:7];

    encap_result_reader #(.parameter_set(4), .READ_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_C0(b_rd_C0), .C0_addr(b_C0_addr), .C0_out(b_C0_out),
        .rd_C1(b_rd_C1), .C1_addr(b_C1_addr), .C1_out(b_C1_out),
        .rd_K(b_rd_K), .K_addr(b_K_addr), .K_out(b_K_out),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_ready));

    always @(posedge clk) begin
        b_s0 <= b_rd_C0 ? b_c0[b_C0_addr] : 32'hDEADBEEF;
        b_s1 <= b_rd_C1 ? b_c1[b_C1_addr] : 32'hDEADBEEF;
        b_s2 <= b_rd_K  ? b_k[b_K_addr]   : 32'hDEADBEEF;
        b_C0_out <= b_s0;
        b_C1_out <= b_s1;
        b_K_out  <= b_s2;
    end

    // ---------------- monitors (sample on the falling edge) ----------------
    logic [7:0] a_got[$], a_exp[$], b_got[$], b_exp[$];
    int a_last_hs, a_done_cnt, a_done_cyc, a_done_busy, a_unstable, a_overlap, a_long, a_badaddr;
    int a_n0, a_n1, a_n2;
    bit a_pend, a_p0, a_p1, a_p2;
    logic [7:0] a_pdata;
    int b_last_hs, b_done_cnt, b_done_cyc;

    always @(negedge clk) begin
        if (rst) begin
            a_pend = 0; a_p0 = 0; a_p1 = 0; a_p2 = 0;
        end else begin
            if (a_pend && !(a_tx_valid && a_tx_data === a_pdata)) a_unstable++;
            a_pend  = a_tx_valid && !a_ready;
            a_pdata = a_tx_data;
            if (a_tx_valid && a_ready) begin a_got.push_back(a_tx_data); a_last_hs = cyc; end
            if (a_done) begin a_done_cnt++; a_done_cyc = cyc; a_done_busy = int'(a_busy); end
            if (int'(a_rd_C0) + int'(a_rd_C1) + int'(a_rd_K) > 1) a_overlap++;
            if (a_rd_C0) begin if (a_p0) a_long++; if (a_C0_addr != 5'(a_n0)) a_badaddr++; a_n0++; end
            if (a_rd_C1) begin if (a_p1) a_long++; if (a_C1_addr != 3'(a_n1)) a_badaddr++; a_n1++; end
            if (a_rd_K)  begin if (a_p2) a_long++; if (a_K_addr  != 3'(a_n2)) a_badaddr++; a_n2++; end
            a_p0 = a_rd_C0; a_p1 = a_rd_C1; a_p2 = a_rd_K;
            if (b_tx_valid && b_ready) begin b_got.push_back(b_tx_data); b_last_hs = cyc; end
            if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_a();
        a_got.delete();
        a_last_hs = -1; a_done_cnt = 0; a_done_cyc = -1; a_done_busy = -1;
        a_unstable = 0; a_overlap = 0; a_long = 0; a_badaddr = 0;
        a_n0 = 0; a_n1 = 0; a_n2 = 0;
    endtask

    // Reference stream: every word of each region in order, least significant byte first.
    task automatic build_a();
        a_exp.delete();
        foreach (a_c0[i]) for (int b = 0; b < 4; b++) a_exp.push_back(a_c0[i][8*b +: 8]);
        foreach (a_c1[i]) for (int b = 0; b < 4; b++) a_exp.push_back(a_c1[i][8*b +: 8]);
        foreach (a_k[i])  for (int b = 0; b < 4; b++) a_exp.push_back(a_k[i][8*b +: 8]);
    endtask

    task automatic rand_a();
        foreach (a_c0[i]) a_c0[i] = $urandom;
        foreach (a_c1[i]) a_c1[i] = $urandom;
        foreach (a_k[i])  a_k[i]  = $urandom;
    endtask

    function automatic int stream_bad(input logic [7:0] got[$], input logic [7:0] exp[$]);
        int n = 0;
        for (int i = 0; i < exp.size(); i++)
            if (i >= got.size() || got[i] !== exp[i]) n++;
        return n;
    endfunction

    // One full run on DUT A; restart re-pulses start at cycles 50 and 100 of the run.
    task automatic run_a(input int pct, input bit restart, output int s);
        clr_a();
        build_a();
        a_ready = (pct >= 100) ? 1'b1 : 1'b0;
        @(posedge clk); #1;
        a_start = 1'b1;
        s = cyc;
        for (int i = 0; i < 6000 && a_done_cnt == 0; i++) begin
            @(posedge clk); #1;
            a_start = restart && (cyc == s + 50 || cyc == s + 100);
            a_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
        end
        a_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic chk_a_run(input string tag, input int s, input bit timing);
        chk({tag, "_bytes"}, a_got.size(), 160);
        chk({tag, "_data"}, stream_bad(a_got, a_exp), 0);
        chk({tag, "_done_cnt"}, a_done_cnt, 1);
        chk({tag, "_done_busy"}, a_done_busy, 0);
        chk({tag, "_unstable"}, a_unstable, 0);
        if (timing) begin
            chk({tag, "_last_hs"}, a_last_hs - s, 240);
            chk({tag, "_done_cyc"}, a_done_cyc - s, 241);
        end
    endtask

    initial begin
        int s;
        rst = 1'b1; a_start = 0; a_ready = 0; b_start = 0; b_ready = 0;
        foreach (a_c0[i]) a_c0[i] = 32'hC000_0000 + i;
        foreach (a_c1[i]) a_c1[i] = 32'hC100_0000 + i;
        foreach (a_k[i])  a_k[i]  = 32'h4B00_0000 + i;
        foreach (b_c0[i]) b_c0[i] = $urandom;
        foreach (b_c1[i]) b_c1[i] = $urandom;
        foreach (b_k[i])  b_k[i]  = $urandom;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("a_reset_outs", {a_busy, a_done, a_rd_C0, a_C0_addr, a_rd_C1, a_C1_addr,
                             a_rd_K, a_K_addr, a_tx_data, a_tx_valid}, 0);
        chk("b_reset_outs", {b_busy, b_done, b_rd_C0, b_C0_addr, b_rd_C1, b_C1_addr,
                             b_rd_K, b_K_addr, b_tx_data, b_tx_valid}, 0);

        // Fixed pattern, ready held high, plus read-strobe accounting.
        run_a(100, 0, s);
        chk_a_run("t1", s, 1);
        chk("t1_first8", {a_got[0], a_got[1], a_got[2], a_got[3],
                          a_got[4], a_got[5], a_got[6], a_got[7]}, 64'h000000C0_010000C0);
        chk("t1_byte96", a_got[96], 8'h00);
        chk("t1_last4", {a_got[156], a_got[157], a_got[158], a_got[159]}, 32'h0700004B);
        chk("t3_rd_C0", a_n0, 24);
        chk("t3_rd_C1", a_n1, 8);
        chk("t3_rd_K", a_n2, 8);
        chk("t3_long", a_long, 0);
        chk("t3_addr", a_badaddr, 0);
        chk("t3_overlap", a_overlap, 0);

        // Random data, throttled sink.
        rand_a();
        run_a(30, 0, s);
        chk_a_run("t2", s, 0);

        // Start re-asserted mid-run must be ignored.
        rand_a();
        run_a(100, 1, s);
        chk_a_run("t4", s, 1);

        // Reset after byte 70 aborts without done, then a fresh run.
        clr_a();
        a_ready = 1'b1;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        for (int i = 0; i < 2000 && a_got.size() < 70; i++) begin @(posedge clk); #1; end
        chk("t5_reached70", a_got.size() >= 70, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_reset_outs", {a_busy, a_done, a_rd_C0, a_C0_addr, a_rd_C1, a_C1_addr,
                              a_rd_K, a_K_addr, a_tx_data, a_tx_valid}, 0);
        repeat (300) @(posedge clk);
        #1;
        chk("t5_no_done", a_done_cnt, 0);
        rand_a();
        run_a(100, 0, s);
        chk_a_run("t5_rerun", s, 1);

        // Set 4, latency 2.
        b_got.delete(); b_exp.delete(); b_done_cnt = 0; b_last_hs = -1; b_done_cyc = -1;
        foreach (b_c0[i]) for (int b = 0; b < 4; b++) b_exp.push_back(b_c0[i][8*b +: 8]);
        foreach (b_c1[i]) for (int b = 0; b < 4; b++) b_exp.push_back(b_c1[i][8*b +: 8]);
        foreach (b_k[i])  for (int b = 0; b < 4; b++) b_exp.push_back(b_k[i][8*b +: 8]);
        b_ready = 1'b1;
        @(posedge clk); #1 b_start = 1'b1;
        s = cyc;
        @(posedge clk); #1 b_start = 1'b0;
        for (int i = 0; i < 2000 && b_done_cnt == 0; i++) begin @(posedge clk); #1; end
        repeat (10) @(posedge clk);
        #1;
        chk("t6_bytes", b_got.size(), 260);
        chk("t6_data", stream_bad(b_got, b_exp), 0);
        chk("t6_done_cnt", b_done_cnt, 1);
        chk("t6_last_hs", b_last_hs - s, 455);
        chk("t6_done_cyc", b_done_cyc - s, 456);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
